// File: rtl/relu.sv
// relu: rectifies LENGTH signed elements in parallel and registers the result.
// A result is loaded on each rising edge with en high, and out_valid pulses
// for one cycle. With en low, Out holds its value and out_valid drops.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous, active-low reset; clears Out and out_valid
//   en         - load enable, sampled on the rising edge
//   In         - input elements, two's-complement, DATA_WIDTH bits each
//   Out        - registered rectified elements, the same width as In
//   out_valid  - registered; high for one cycle after each edge with en high
module relu #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LENGTH     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] In  [0:LENGTH-1],
  output logic [DATA_WIDTH-1:0] Out [0:LENGTH-1],
  output logic                  out_valid
);

  logic [DATA_WIDTH-1:0] rect_c [0:LENGTH-1];

  // Per-element rectifier. A set sign bit gives zero, so the most-negative value also gives zero.
  always_comb begin
    for (int unsigned i = 0; i < LENGTH; i++) begin
      rect_c[i] = In[i][DATA_WIDTH-1] ? '0 : In[i];
    end
  end

  // Output register. It holds its value while en is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LENGTH; i++) begin
        Out[i] <= '0;
      end
      out_valid <= 1'b0;
    end else begin
      out_valid <= en;
      if (en) begin
        for (int unsigned i = 0; i < LENGTH; i++) begin
          Out[i] <= rect_c[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_relu.sv
// tb_relu: directed and randomized checks of relu. Two instances are used:
// the default 16x4 instance and a 3-bit, single-element instance.
module tb_relu;

  localparam int unsigned DW  = 16;
  localparam int unsigned LEN = 4;
  localparam int unsigned SDW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [DW-1:0] in_v  [0:LEN-1];
  logic [DW-1:0] out_v [0:LEN-1];
  logic          out_valid;

  logic           s_en;
  logic [SDW-1:0] s_in  [0:0];
  logic [SDW-1:0] s_out [0:0];
  logic           s_valid;

  // Expected state of the outputs
  logic [DW-1:0]  exp_out [0:LEN-1];
  logic           exp_valid;
  logic [SDW-1:0] s_exp;
  logic           s_exp_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  relu #(.DATA_WIDTH(DW), .LENGTH(LEN)) u_dut (
    .clk(clk), .reset(reset), .en(en), .In(in_v), .Out(out_v), .out_valid(out_valid)
  );

  relu #(.DATA_WIDTH(SDW), .LENGTH(1)) u_small (
    .clk(clk), .reset(reset), .en(s_en), .In(s_in), .Out(s_out), .out_valid(s_valid)
  );

  // Reference rectifier: a negative value gives zero, and any other value passes unchanged
  function automatic logic [DW-1:0] ref16(input logic [DW-1:0] x);
    int v;
    v = int'($signed(x));
    return (v < 0) ? 16'd0 : x;
  endfunction

  function automatic logic [SDW-1:0] ref3(input logic [SDW-1:0] x);
    int v;
    v = int'($signed(x));
    return (v < 0) ? 3'd0 : x;
  endfunction

  // Half of the elements are boundary values and the rest are uniform random
  function automatic logic [DW-1:0] rand_elem();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return DW'($urandom);
    endcase
  endfunction

  function automatic logic [LEN*DW-1:0] rand_vec();
    logic [LEN*DW-1:0] pv;
    for (int i = 0; i < LEN; i++) pv[i*DW +: DW] = rand_elem();
    return pv;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < LEN; i++) begin
      check($sformatf("%s out[%0d]", tag, i), 32'(out_v[i]), 32'(exp_out[i]));
    end
    check({tag, " out_valid"}, 32'(out_valid), 32'(exp_valid));
    check({tag, " small out"}, 32'(s_out[0]), 32'(s_exp));
    check({tag, " small valid"}, 32'(s_valid), 32'(s_exp_valid));
  endtask

  task automatic clear_model();
    for (int i = 0; i < LEN; i++) exp_out[i] = '0;
    exp_valid   = 1'b0;
    s_exp       = '0;
    s_exp_valid = 1'b0;
  endtask

  // Apply one vector on one edge, with In[0] in the most significant slot of pv.
  // Then check the result, change the inputs, and check that Out has not moved.
  task automatic step(input string tag, input logic [LEN*DW-1:0] pv, input logic e);
    @(negedge clk);
    for (int i = 0; i < LEN; i++) in_v[i] = pv[(LEN-1-i)*DW +: DW];
    en       = e;
    s_in[0]  = SDW'($urandom);
    s_en     = 1'($urandom);
    @(posedge clk);
    if (e) begin
      for (int i = 0; i < LEN; i++) exp_out[i] = ref16(pv[(LEN-1-i)*DW +: DW]);
    end
    exp_valid = e;
    if (s_en) s_exp = ref3(s_in[0]);
    s_exp_valid = s_en;
    #1;
    check_all(tag);
    for (int i = 0; i < LEN; i++) in_v[i] = ~in_v[i];
    s_in[0] = ~s_in[0];
    en      = ~en;
    s_en    = ~s_en;
    #1;
    check_all({tag, " stable"});
  endtask

  initial begin
    reset   = 1'b1;
    en      = 1'b0;
    s_en    = 1'b0;
    s_in[0] = '0;
    for (int i = 0; i < LEN; i++) in_v[i] = '0;
    clear_model();

    // Assert reset before the first clock edge, with en and the inputs active
    #3;
    in_v[0] = 16'h7FFF; in_v[1] = 16'h8000; in_v[2] = 16'hFFFF; in_v[3] = 16'h0001;
    en      = 1'b1;
    s_in[0] = 3'b011;
    s_en    = 1'b1;
    reset   = 1'b0;
    #1;
    check_all("reset async");
    repeat (2) @(posedge clk);
    #1;
    check_all("reset held");

    // Release reset with en low; the outputs stay zero
    @(negedge clk);
    en    = 1'b0;
    s_en  = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all("post reset idle");

    step("mixed",   {16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF}, 1'b1);
    step("all pos", {16'h0001, 16'h000A, 16'h00FF, 16'h7FFF}, 1'b1);
    step("all neg", {16'h8001, 16'hFFFE, 16'hFFFF, 16'h8000}, 1'b1);
    step("load",    {16'h0005, 16'h0006, 16'h0007, 16'h0008}, 1'b1);
    step("hold1",   {16'h0001, 16'h0001, 16'h0001, 16'h0001}, 1'b0);
    step("hold2",   {16'h0001, 16'h0001, 16'h0001, 16'h0001}, 1'b0);

    // Back-to-back vectors with en held high
    repeat (30) step("b2b", rand_vec(), 1'b1);

    // Random en pattern
    repeat (40) step("rand en", rand_vec(), 1'($urandom));

    // Reset asserted in mid-operation clears the outputs at once
    step("pre reset", {16'h1234, 16'h7FFF, 16'h0001, 16'h4000}, 1'b1);
    reset = 1'b0;
    clear_model();
    #1;
    check_all("mid reset");
    @(negedge clk);
    reset = 1'b1;
    step("after reset", rand_vec(), 1'b1);
    step("after reset2", rand_vec(), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
